// File: rtl/tl_pkg.sv
// TileLink-UH opcodes, channel payload types and the beat-count helper
// shared by the source remapper and its free-ID pool.
package tl_pkg;

  localparam int HostSourceWidth   = 8;
  localparam int DeviceSourceWidth = 3;
  localparam int SinkWidth         = 1;
  localparam int AddrWidth         = 56;
  localparam int DataWidth         = 64;
  localparam int SizeWidth         = 4;
  // Largest transfer the burst counters are sized for (64-byte bursts).
  localparam int TlMaxSize         = 6;
  localparam int TlMaxBeats        = 2 ** (TlMaxSize - $clog2(DataWidth / 8));
  localparam int BeatCntWidth      = $clog2(TlMaxBeats) + 1;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITH       = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_INTENT      = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } tl_d_op_e;

  typedef struct packed {
    tl_a_op_e                   opcode;
    logic [2:0]                 param;
    logic [SizeWidth-1:0]       size;
    logic [HostSourceWidth-1:0] source;
    logic [AddrWidth-1:0]       address;
    logic [DataWidth/8-1:0]     mask;
    logic [DataWidth-1:0]       data;
    logic                       corrupt;
  } tl_a_host_t;

  typedef struct packed {
    tl_a_op_e                     opcode;
    logic [2:0]                   param;
    logic [SizeWidth-1:0]         size;
    logic [DeviceSourceWidth-1:0] source;
    logic [AddrWidth-1:0]         address;
    logic [DataWidth/8-1:0]       mask;
    logic [DataWidth-1:0]         data;
    logic                         corrupt;
  } tl_a_dev_t;

  typedef struct packed {
    tl_d_op_e                   opcode;
    logic [1:0]                 param;
    logic [SizeWidth-1:0]       size;
    logic [HostSourceWidth-1:0] source;
    logic [SinkWidth-1:0]       sink;
    logic                       denied;
    logic [DataWidth-1:0]       data;
    logic                       corrupt;
  } tl_d_host_t;

  typedef struct packed {
    tl_d_op_e                     opcode;
    logic [1:0]                   param;
    logic [SizeWidth-1:0]         size;
    logic [DeviceSourceWidth-1:0] source;
    logic [SinkWidth-1:0]         sink;
    logic                         denied;
    logic [DataWidth-1:0]         data;
    logic                         corrupt;
  } tl_d_dev_t;

  function automatic logic tl_a_has_data(input tl_a_op_e op);
    return op inside {A_PUT_FULL, A_PUT_PARTIAL, A_ARITH, A_LOGICAL};
  endfunction

  function automatic logic tl_d_has_data(input tl_d_op_e op);
    return op == D_ACCESS_ACK_DATA;
  endfunction

  // Beats in a message; sizes above TlMaxSize are clamped to keep the counter in range.
  function automatic logic [BeatCntWidth-1:0] tl_beats(input logic has_data,
                                                       input logic [SizeWidth-1:0] size,
                                                       input int data_width);
    int lg;
    int sz;
    lg = $clog2(data_width / 8);
    sz = (int'(size) > TlMaxSize) ? TlMaxSize : int'(size);
    if (!has_data || sz <= lg) return BeatCntWidth'(1);
    return BeatCntWidth'(1 << (sz - lg));
  endfunction

endpackage

// File: rtl/tl_source_pool.sv
// Free-list bitmap of device source IDs; hands out the lowest free ID.
// A freed ID becomes visible to the encoder only after the register update.
module tl_source_pool
  import tl_pkg::*;
#(
  parameter int Entries = 8,
  parameter int IdWidth = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alloc_i,
  input  logic               free_i,
  input  logic [IdWidth-1:0] free_id_i,
  output logic               any_free_o,
  output logic [IdWidth-1:0] alloc_id_o,
  output logic [Entries-1:0] used_o
);

  logic [Entries-1:0] used;

  always_comb begin
    alloc_id_o = '0;
    for (int i = Entries - 1; i >= 0; i--) begin
      if (!used[i]) alloc_id_o = IdWidth'(i);
    end
  end

  assign any_free_o = ~&used;
  assign used_o     = used;

  // Allocation and free in one cycle always target different entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used <= '0;
    end else begin
      if (alloc_i) used[alloc_id_o] <= 1'b1;
      if (free_i)  used[free_id_i]  <= 1'b0;
    end
  end

endmodule

// File: rtl/tl_source_remapper.sv
// Dynamic TileLink-UH source remapper: host A messages are given a free device
// ID, D responses are translated back through the host-source table.
module tl_source_remapper
  import tl_pkg::*;
#(
  parameter int MaxOutstanding = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       host_a_ready,
  input  logic       host_a_valid,
  input  tl_a_host_t host_a,
  input  logic       host_d_ready,
  output logic       host_d_valid,
  output tl_d_host_t host_d,
  input  logic       device_a_ready,
  output logic       device_a_valid,
  output tl_a_dev_t  device_a,
  output logic       device_d_ready,
  input  logic       device_d_valid,
  input  tl_d_dev_t  device_d,
  output logic       idle_o
);

  logic [HostSourceWidth-1:0]   host_src [MaxOutstanding];
  logic [BeatCntWidth-1:0]      a_cnt;
  logic [BeatCntWidth-1:0]      d_cnt;
  logic [DeviceSourceWidth-1:0] a_lock_id;

  logic                         any_free;
  logic [DeviceSourceWidth-1:0] pool_id;
  logic [MaxOutstanding-1:0]    pool_used;

  logic                         a_first;
  logic                         a_gate;
  logic                         a_fire;
  logic                         alloc;
  logic [DeviceSourceWidth-1:0] a_id;
  logic [BeatCntWidth-1:0]      a_beats;
  logic                         d_fire;
  logic                         d_last;
  logic [BeatCntWidth-1:0]      d_beats;

  // Only a first beat needs a fresh ID; later beats ride on the locked one.
  assign a_first        = (a_cnt == '0);
  assign a_gate         = !a_first || any_free;
  assign a_id           = a_first ? pool_id : a_lock_id;
  assign device_a_valid = host_a_valid & a_gate;
  assign host_a_ready   = device_a_ready & a_gate;
  assign a_fire         = host_a_valid & host_a_ready;
  assign alloc          = a_fire & a_first;
  assign a_beats        = tl_beats(tl_a_has_data(host_a.opcode), host_a.size, DataWidth);

  assign host_d_valid   = device_d_valid;
  assign device_d_ready = host_d_ready;
  assign d_fire         = device_d_valid & host_d_ready;
  assign d_beats        = tl_beats(tl_d_has_data(device_d.opcode), device_d.size, DataWidth);
  assign d_last         = (d_cnt == '0) ? (d_beats == BeatCntWidth'(1))
                                        : (d_cnt == BeatCntWidth'(1));

  always_comb begin
    device_a.opcode  = host_a.opcode;
    device_a.param   = host_a.param;
    device_a.size    = host_a.size;
    device_a.source  = a_id;
    device_a.address = host_a.address;
    device_a.mask    = host_a.mask;
    device_a.data    = host_a.data;
    device_a.corrupt = host_a.corrupt;

    host_d.opcode    = device_d.opcode;
    host_d.param     = device_d.param;
    host_d.size      = device_d.size;
    host_d.source    = host_src[device_d.source];
    host_d.sink      = device_d.sink;
    host_d.denied    = device_d.denied;
    host_d.data      = device_d.data;
    host_d.corrupt   = device_d.corrupt;
  end

  tl_source_pool #(
    .Entries (MaxOutstanding),
    .IdWidth (DeviceSourceWidth)
  ) u_pool (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alloc_i    (alloc),
    .free_i     (d_fire & d_last),
    .free_id_i  (device_d.source),
    .any_free_o (any_free),
    .alloc_id_o (pool_id),
    .used_o     (pool_used)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_cnt     <= '0;
      a_lock_id <= '0;
      d_cnt     <= '0;
      for (int i = 0; i < MaxOutstanding; i++) host_src[i] <= '0;
    end else begin
      if (a_fire) begin
        if (a_first) begin
          a_cnt              <= a_beats - BeatCntWidth'(1);
          a_lock_id          <= pool_id;
          host_src[pool_id]  <= host_a.source;
        end else begin
          a_cnt <= a_cnt - BeatCntWidth'(1);
        end
      end
      if (d_fire) begin
        d_cnt <= (d_cnt == '0) ? d_beats - BeatCntWidth'(1) : d_cnt - BeatCntWidth'(1);
      end
    end
  end

  assign idle_o = ~|pool_used & (a_cnt == '0) & (d_cnt == '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && host_a_valid) begin
      assert (host_a.opcode inside {A_PUT_FULL, A_PUT_PARTIAL, A_ARITH,
                                    A_LOGICAL, A_GET, A_INTENT});
    end
    if (!rst_i && device_d_valid) begin
      assert (device_d.opcode inside {D_ACCESS_ACK, D_ACCESS_ACK_DATA, D_HINT_ACK});
      assert (int'(device_d.source) < MaxOutstanding);
      assert (pool_used[device_d.source]);
    end
  end
`endif

endmodule

// File: tb/tb_tl_source_remapper.sv
// Directed, table-driven bench for tl_source_remapper: one vector per cycle,
// plus a hand-written reset-mid-burst sequence.
module tb_tl_source_remapper;
  import tl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       host_a_ready, host_a_valid;
  tl_a_host_t host_a;
  logic       host_d_ready, host_d_valid;
  tl_d_host_t host_d;
  logic       device_a_ready, device_a_valid;
  tl_a_dev_t  device_a;
  logic       device_d_ready, device_d_valid;
  tl_d_dev_t  device_d;
  logic       idle_o;

  int total = 0;
  int bad   = 0;
  int rows  = 0;

  always #5 clk_i = ~clk_i;

  tl_source_remapper dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .host_a_ready   (host_a_ready),
    .host_a_valid   (host_a_valid),
    .host_a         (host_a),
    .host_d_ready   (host_d_ready),
    .host_d_valid   (host_d_valid),
    .host_d         (host_d),
    .device_a_ready (device_a_ready),
    .device_a_valid (device_a_valid),
    .device_a       (device_a),
    .device_d_ready (device_d_ready),
    .device_d_valid (device_d_valid),
    .device_d       (device_d),
    .idle_o         (idle_o)
  );

  typedef struct {
    logic       av;
    tl_a_op_e   aop;
    logic [3:0] asz;
    logic [7:0] asrc;
    logic       ar;
    logic       dv;
    tl_d_op_e   dop;
    logic [3:0] dsz;
    logic [2:0] dsrc;
    logic       dr;
    logic       x_ar;
    logic       x_av;
    logic [2:0] x_asrc;
    logic [7:0] x_dsrc;
    logic       x_idle;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic av, tl_a_op_e aop, int asz, int asrc, logic ar,
                              logic dv, tl_d_op_e dop, int dsz, int dsrc, logic dr,
                              logic xar, logic xav, int xasrc, int xdsrc, logic xidle);
    vec_t v;
    v.av = av;  v.aop = aop;  v.asz = 4'(asz);  v.asrc = 8'(asrc);  v.ar = ar;
    v.dv = dv;  v.dop = dop;  v.dsz = 4'(dsz);  v.dsrc = 3'(dsrc);  v.dr = dr;
    v.x_ar = xar;  v.x_av = xav;  v.x_asrc = 3'(xasrc);  v.x_dsrc = 8'(xdsrc);
    v.x_idle = xidle;
    return v;
  endfunction

  function automatic vec_t idle_row(logic xidle);
    return mk(0, A_GET, 0, 0, 0, 0, D_ACCESS_ACK, 0, 0, 0, 0, 0, 0, 0, xidle);
  endfunction

  function automatic vec_t d_row(tl_d_op_e dop, int dsz, int dsrc, int xdsrc);
    return mk(0, A_GET, 0, 0, 0, 1, dop, dsz, dsrc, 1, 0, 0, 0, xdsrc, 0);
  endfunction

  function automatic logic [AddrWidth-1:0] addr_of(int idx);
    return AddrWidth'(64'h00AB_0000_0000) + AddrWidth'(idx);
  endfunction

  function automatic logic [DataWidth-1:0] adata_of(int idx);
    return {32'hC0FF_EE00, 32'(idx)};
  endfunction

  function automatic logic [DataWidth-1:0] ddata_of(int idx);
    return {32'hFACE_0000, 32'(idx)};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst_i            = 1'b0;
    host_a_valid     = v.av;
    host_a.opcode    = v.aop;
    host_a.param     = '0;
    host_a.size      = v.asz;
    host_a.source    = v.asrc;
    host_a.address   = addr_of(idx);
    host_a.mask      = '1;
    host_a.data      = adata_of(idx);
    host_a.corrupt   = 1'b0;
    device_a_ready   = v.ar;
    device_d_valid   = v.dv;
    device_d.opcode  = v.dop;
    device_d.param   = '0;
    device_d.size    = v.dsz;
    device_d.source  = v.dsrc;
    device_d.sink    = SinkWidth'(idx & 1);
    device_d.denied  = 1'b0;
    device_d.data    = ddata_of(idx);
    device_d.corrupt = 1'b0;
    host_d_ready     = v.dr;
  endtask

  task automatic check(input vec_t v, input int idx);
    logic pay_ok;
    chk("host_a_ready", idx, 32'(host_a_ready), 32'(v.x_ar));
    chk("device_a_valid", idx, 32'(device_a_valid), 32'(v.x_av));
    if (v.x_av) chk("device_a.source", idx, 32'(device_a.source), 32'(v.x_asrc));
    if (v.dv) chk("host_d.source", idx, 32'(host_d.source), 32'(v.x_dsrc));
    chk("host_d_valid", idx, 32'(host_d_valid), 32'(v.dv));
    chk("device_d_ready", idx, 32'(device_d_ready), 32'(v.dr));
    chk("idle_o", idx, 32'(idle_o), 32'(v.x_idle));
    pay_ok = (device_a.address == addr_of(idx)) && (device_a.data == adata_of(idx)) &&
             (device_a.opcode == v.aop) && (device_a.size == v.asz) &&
             (host_d.data == ddata_of(idx)) && (host_d.opcode == v.dop) &&
             (host_d.size == v.dsz) && (host_d.sink == SinkWidth'(idx & 1));
    chk("payload_passthrough", idx, 32'(pay_ok), 32'd1);
  endtask

  task automatic run(input vec_t v);
    @(posedge clk_i);
    #1;
    apply(v, rows);
    #2;
    check(v, rows);
    rows++;
  endtask

  initial begin
    apply(idle_row(1), 0);
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);

    // reset state; single Get round trip
    tv.push_back(mk(0, A_GET, 0, 0, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 0, 0, 0, 1));
    tv.push_back(mk(1, A_GET, 3, 'hA5, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 1));
    tv.push_back(mk(0, A_GET, 0, 0, 0, 1, D_ACCESS_ACK_DATA, 3, 0, 1, 0, 0, 0, 'hA5, 0));
    tv.push_back(idle_row(1));

    // fill the pool, stall, free/allocate
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, A_GET, 2, 'h10 + i, 1, 0, D_ACCESS_ACK, 0, 0, 0,
                      1, 1, i, 0, (i == 0)));
    tv.push_back(mk(1, A_GET, 2, 'h18, 1, 0, D_ACCESS_ACK, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, A_GET, 2, 'h18, 1, 1, D_ACCESS_ACK, 2, 3, 1, 0, 0, 0, 'h13, 0));
    tv.push_back(mk(1, A_GET, 2, 'h18, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 3, 0, 0));
    tv.push_back(mk(1, A_GET, 2, 'h20, 1, 1, D_ACCESS_ACK, 2, 0, 1, 0, 0, 0, 'h10, 0));
    tv.push_back(mk(1, A_GET, 2, 'h20, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(d_row(D_ACCESS_ACK, 2, 1, 'h11));
    tv.push_back(mk(1, A_GET, 2, 'h21, 1, 1, D_ACCESS_ACK, 2, 2, 1, 1, 1, 1, 'h12, 0));
    tv.push_back(mk(1, A_GET, 2, 'h22, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 2, 0, 0));
    begin
      int hs[8] = '{'h20, 'h21, 'h22, 'h18, 'h14, 'h15, 'h16, 'h17};
      for (int k = 0; k < 8; k++) tv.push_back(d_row(D_ACCESS_ACK, 2, k, hs[k]));
    end
    tv.push_back(idle_row(1));

    // 8-beat PutFull keeps its ID across a D free and A back-pressure
    tv.push_back(mk(1, A_GET, 2, 'h31, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 1));
    tv.push_back(mk(1, A_PUT_FULL, 6, 'h30, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 1, 0, 0));
    tv.push_back(mk(1, A_PUT_FULL, 6, 'h30, 1, 1, D_ACCESS_ACK, 6, 0, 1, 1, 1, 1, 'h31, 0));
    tv.push_back(mk(1, A_PUT_FULL, 6, 'h30, 0, 0, D_ACCESS_ACK, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int b = 2; b < 8; b++)
      tv.push_back(mk(1, A_PUT_FULL, 6, 'h30, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 1, 0, 0));
    tv.push_back(mk(1, A_GET, 2, 'h32, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(d_row(D_ACCESS_ACK, 6, 1, 'h30));
    tv.push_back(d_row(D_ACCESS_ACK, 2, 0, 'h32));
    tv.push_back(idle_row(1));

    // 8-beat AccessAckData holds its entry until the last beat handshakes
    tv.push_back(mk(1, A_GET, 6, 'h40, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 1));
    for (int b = 0; b < 3; b++) tv.push_back(d_row(D_ACCESS_ACK_DATA, 6, 0, 'h40));
    tv.push_back(mk(1, A_GET, 2, 'h41, 1, 1, D_ACCESS_ACK_DATA, 6, 0, 1, 1, 1, 1, 'h40, 0));
    for (int b = 0; b < 3; b++) tv.push_back(d_row(D_ACCESS_ACK_DATA, 6, 0, 'h40));
    tv.push_back(mk(1, A_GET, 2, 'h42, 1, 1, D_ACCESS_ACK_DATA, 6, 0, 0, 1, 1, 2, 'h40, 0));
    tv.push_back(d_row(D_ACCESS_ACK_DATA, 6, 0, 'h40));
    tv.push_back(mk(1, A_GET, 2, 'h43, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 0));
    tv.push_back(d_row(D_ACCESS_ACK_DATA, 3, 1, 'h41));
    tv.push_back(d_row(D_ACCESS_ACK_DATA, 3, 2, 'h42));
    tv.push_back(d_row(D_ACCESS_ACK_DATA, 3, 0, 'h43));
    tv.push_back(idle_row(1));

    foreach (tv[i]) run(tv[i]);

    // reset in the middle of a PutFull burst
    run(mk(1, A_GET, 2, 'h4F, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 1));
    run(mk(1, A_PUT_FULL, 6, 'h50, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 1, 0, 0));
    run(mk(1, A_PUT_FULL, 6, 'h50, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 1, 0, 0));
    run(mk(1, A_PUT_FULL, 6, 'h50, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 1, 0, 0));
    repeat (2) begin
      @(posedge clk_i);
      #1;
      apply(idle_row(1), rows);
      rst_i = 1'b1;
    end
    run(idle_row(1));
    run(mk(1, A_GET, 2, 'h51, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 0, 0, 1));
    run(mk(1, A_GET, 2, 'h52, 1, 0, D_ACCESS_ACK, 0, 0, 0, 1, 1, 1, 0, 0));
    run(d_row(D_ACCESS_ACK_DATA, 3, 0, 'h51));
    run(d_row(D_ACCESS_ACK_DATA, 3, 1, 'h52));
    run(idle_row(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
